// File: rtl/cic_decimator.sv
// Fixed-ratio CIC decimator: NS pipelined integrators at the input rate,
// decimation on the upstream terminal-count strobe, NS comb stages with
// differential delay 1, truncated output taken from the top OW bits.
module cic_decimator #(
  parameter int unsigned DW = 16,
  parameter int unsigned R  = 64,
  parameter int unsigned NS = 3,
  parameter int unsigned BW = DW + NS * $clog2(R),
  parameter int unsigned OW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  input  logic                 dec_stb,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid
);

  // Integrator chain; wraps modulo 2^BW, the combs cancel the wrap.
  logic signed [BW-1:0] integ_q [NS];
  logic signed [BW-1:0] integ_d [NS];
  // comb_q[0] is the decimated capture, comb_q[k] the output of comb stage k.
  logic signed [BW-1:0] comb_q [NS+1];
  logic signed [BW-1:0] comb_d [NS+1];
  // dly_q[k-1] is the differential-delay register of comb stage k.
  logic signed [BW-1:0] dly_q [NS];
  logic signed [BW-1:0] dly_d [NS];
  logic [NS:0]          vld_q;
  logic [NS:0]          vld_d;
  logic signed [BW-1:0] din_ext;

  assign din_ext = BW'(din);

  // Next-state for integrators, decimation capture and comb pipeline.
  always_comb begin
    integ_d = integ_q;
    comb_d  = comb_q;
    dly_d   = dly_q;
    vld_d   = '0;
    if (en) begin
      integ_d[0] = integ_q[0] + din_ext;
      for (int k = 1; k < NS; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
    if (en && dec_stb) begin
      comb_d[0] = integ_q[NS-1];
      vld_d[0]  = 1'b1;
    end
    for (int k = 1; k <= NS; k++) begin
      if (vld_q[k-1]) begin
        comb_d[k]  = comb_q[k-1] - dly_q[k-1];
        dly_d[k-1] = comb_q[k-1];
        vld_d[k]   = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      for (int k = 0; k <= NS; k++) begin
        comb_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      integ_q <= integ_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
      vld_q   <= vld_d;
    end
  end

  assign dout       = comb_q[NS][BW-1 -: OW];
  assign dout_valid = vld_q[NS];

  // Truncated LSBs are intentionally dropped.
  if (OW < BW) begin : g_trunc
    logic unused_lsb;
    assign unused_lsb = ^comb_q[NS][BW-OW-1:0];
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: two instances (DW=8/R=4/OW=14 and
// default parameters) share clk/rst_n/en/dec_stb. Expected outputs come from a
// closed-form model: the NS-th integrator after n samples is a binomially
// weighted sum of the input history, the comb output is the NS-th finite
// difference of the decimated sequence.
module tb_cic_decimator;
  localparam int NS  = 3;
  localparam int BWA = 14;
  localparam int OWA = 14;
  localparam int BWB = 34;
  localparam int OWB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               en;
  logic               dec_stb;
  logic signed [7:0]  din_a;
  logic signed [15:0] din_b;
  logic signed [13:0] dout_a;
  logic signed [15:0] dout_b;
  logic               dv_a;
  logic               dv_b;

  cic_decimator #(.DW(8), .R(4), .NS(NS), .OW(OWA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a), .dec_stb(dec_stb),
    .dout(dout_a), .dout_valid(dv_a)
  );

  cic_decimator u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b), .dec_stb(dec_stb),
    .dout(dout_b), .dout_valid(dv_b)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     ecount = 0;
  int     cnt = 0;
  int     cnt_n = 4;
  bit     force_stb = 1'b0;
  longint ha[$];
  longint hb[$];
  longint ya[$];
  longint yb[$];
  longint pa[$];
  longint pb[$];
  int     due[$];
  longint last_a = 0;
  longint last_b = 0;

  function automatic longint binom(input longint a, input int b);
    longint r;
    if (a < 0 || a < longint'(b)) return 0;
    r = 1;
    for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
    return r;
  endfunction

  function automatic longint mask(input longint v, input int bw);
    return v & ((longint'(1) << bw) - 1);
  endfunction

  // Value of the last integrator after all samples in h.
  function automatic longint integ_tap(input longint h[$], input int bw);
    longint s = 0;
    int n = h.size();
    for (int m = 0; m < n; m++) s += h[m] * binom(longint'(n - 1 - m), NS - 1);
    return mask(s, bw);
  endfunction

  // Top OW bits of the NS-th difference of the decimated sequence y.
  function automatic longint comb_top(input longint y[$], input int bw, input int ow);
    longint o = 0;
    int j = y.size() - 1;
    for (int i = 0; i <= NS; i++) begin
      if (j - i >= 0) begin
        if (i % 2 == 1) o -= binom(longint'(NS), i) * y[j-i];
        else            o += binom(longint'(NS), i) * y[j-i];
      end
    end
    return mask(o, bw) >> (bw - ow);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got, input longint want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: drive strobe, update the model at the edge, check #1 later.
  task automatic tick();
    bit exp_v;
    dec_stb = force_stb || (cnt == cnt_n - 1);
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      ha.delete(); hb.delete(); ya.delete(); yb.delete();
      pa.delete(); pb.delete(); due.delete();
      last_a = 0; last_b = 0; cnt = 0;
    end else begin
      if (en && dec_stb) begin
        ya.push_back(integ_tap(ha, BWA));
        yb.push_back(integ_tap(hb, BWB));
        pa.push_back(comb_top(ya, BWA, OWA));
        pb.push_back(comb_top(yb, BWB, OWB));
        due.push_back(ecount + NS);
      end
      if (en) begin
        ha.push_back(longint'(din_a));
        hb.push_back(longint'(din_b));
        cnt = (cnt == cnt_n - 1) ? 0 : cnt + 1;
      end
    end
    #1;
    exp_v = (due.size() > 0) && (due[0] == ecount);
    if (exp_v) begin
      last_a = pa.pop_front();
      last_b = pb.pop_front();
      void'(due.pop_front());
    end
    n_cmp++;
    assert (dv_a === exp_v) else begin
      n_err++; $error("FAIL valid_a edge %0d: got %b want %b", ecount, dv_a, exp_v);
    end
    n_cmp++;
    assert (dv_b === exp_v) else begin
      n_err++; $error("FAIL valid_b edge %0d: got %b want %b", ecount, dv_b, exp_v);
    end
    n_cmp++;
    assert (dout_a === 14'(last_a)) else begin
      n_err++; $error("FAIL dout_a edge %0d: got %h want %h", ecount, dout_a, 14'(last_a));
    end
    n_cmp++;
    assert (dout_b === 16'(last_b)) else begin
      n_err++; $error("FAIL dout_b edge %0d: got %h want %h", ecount, dout_b, 16'(last_b));
    end
  endtask

  task automatic run(input int n, input bit rnd_a, input bit rnd_b, input bit rnd_en);
    for (int i = 0; i < n; i++) begin
      if (rnd_a)  din_a = 8'($urandom);
      if (rnd_b)  din_b = 16'($urandom);
      if (rnd_en) en = 1'($urandom);
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dec_stb = 1'b0; din_a = '0; din_b = '0;
    do_reset(3);
    chk("reset_dout_a", dout_a, 0);
    chk("reset_valid_a", {63'b0, dv_a}, 0);

    // DC gain, positive unit input.
    en = 1'b1; din_a = 8'sd1;
    run(40, 1'b0, 1'b1, 1'b0);
    chk("dc_plus1", dout_a, 64);

    // Negative and positive full scale.
    din_a = -8'sd128;
    run(40, 1'b0, 1'b1, 1'b0);
    chk("dc_neg_fs", dout_a, -8192);
    din_a = 8'sd127;
    run(40, 1'b0, 1'b1, 1'b0);
    chk("dc_pos_fs", dout_a, 8128);

    // Long run so the integrators wrap many times.
    run(10000, 1'b0, 1'b1, 1'b0);
    chk("wrap_pos_fs", dout_a, 8128);

    // Strobe forced while disabled: must be ignored.
    en = 1'b0; force_stb = 1'b1;
    run(10, 1'b1, 1'b1, 1'b0);
    force_stb = 1'b0;
    chk("gated_hold_a", dout_a, 8128);

    // Random data with en toggling.
    run(400, 1'b1, 1'b1, 1'b1);

    // Reset while strobes are in the comb pipeline.
    en = 1'b1;
    for (int i = 0; i < 16 && due.size() == 0; i++) begin
      din_a = 8'($urandom); din_b = 16'($urandom);
      tick();
    end
    chk("inflight_before_rst", longint'(due.size() > 0), 1);
    do_reset(1);
    chk("midrst_dout_a", dout_a, 0);
    chk("midrst_dout_b", dout_b, 0);
    chk("midrst_valid", {63'b0, dv_a}, 0);
    din_a = 8'sd1;
    run(40, 1'b0, 1'b1, 1'b0);
    chk("post_rst_dc", dout_a, 64);

    // Default parameters, truncation, ratio 64.
    do_reset(1);
    cnt_n = 64; din_b = 16'sh7FFF;
    run(64 * 6, 1'b1, 1'b0, 1'b0);
    chk("trunc_pos_fs", dout_b, 32767);
    din_b = -16'sd1;
    run(64 * 6, 1'b1, 1'b0, 1'b0);
    chk("trunc_minus1", dout_b, -1);

    // Strobe every cycle.
    do_reset(1);
    cnt_n = 1;
    run(30, 1'b1, 1'b1, 1'b0);
    run(60, 1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
